nec_ir_decoder: RTL and testbench

Decodes the raw demodulated output of the IR receiver into 32-bit NEC frames for the motor control stage. It sits directly upstream of the motor controller. Each accepted frame is presented on `DataOut` for exactly one `CLK` cycle and is 0 otherwise, so the controller's per-clock command match fires once per key press. Optionally, NEC repeat codes re-emit the last frame so that holding a key keeps stepping the duty cycle.

---
 rtl/nec_pkg.sv | 38 +++
 rtl/nec_edge_sync.sv | 27 ++
 rtl/nec_ir_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_nec_ir_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_pkg.sv
// nec_pkg: shared states, tick thresholds and helpers for the NEC IR decoder.
// The RPT_STOP state only exists when NEC_REPEAT_EN is defined.
package nec_pkg;

    localparam int CNT_W = 11;

    localparam logic [CNT_W-1:0] LEAD_LOW_MIN  = 11'd800;
    localparam logic [CNT_W-1:0] LEAD_LOW_MAX  = 11'd1000;
    localparam logic [CNT_W-1:0] LEAD_HIGH_MIN = 11'd400;
    localparam logic [CNT_W-1:0] LEAD_HIGH_MAX = 11'd500;
    localparam logic [CNT_W-1:0] RPT_HIGH_MIN  = 11'd180;
    localparam logic [CNT_W-1:0] RPT_HIGH_MAX  = 11'd270;
    localparam logic [CNT_W-1:0] BURST_MIN     = 11'd35;
    localparam logic [CNT_W-1:0] BURST_MAX     = 11'd70;
    localparam logic [CNT_W-1:0] ONE_MIN       = 11'd140;
    localparam logic [CNT_W-1:0] ONE_MAX       = 11'd200;
    localparam logic [CNT_W-1:0] TIMEOUT_TICKS = 11'd1100;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP
`ifdef NEC_REPEAT_EN
        , RPT_STOP
`endif
    } state_t;

    // True when a measured pulse width lies inside an inclusive tick window
    function automatic logic in_window(input logic [CNT_W-1:0] ticks,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (ticks >= lo) && (ticks <= hi);
    endfunction

endpackage

// File: rtl/nec_edge_sync.sv
// nec_edge_sync: two-flop synchroniser for the raw IR line plus rise/fall
// detection on the synchronised level. All flops reset to the idle-high level.
module nec_edge_sync
    import nec_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic IR,
    output logic Rise,
    output logic Fall
);

    logic [2:0] sync_q;

    // Shift the line through two metastability flops and one history flop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], IR};
        end
    end

    assign Rise = sync_q[1] & ~sync_q[2];
    assign Fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: measures IR pulse widths in 10 us ticks and decodes 32-bit
// NEC frames, pulsing Valid/DataOut for one cycle per accepted frame and Err
// for one cycle on any framing, timing or check failure.
// Define NEC_REPEAT_EN to have repeat codes re-emit the last good frame.
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IR,
    output logic [31:0] DataOut,
    output logic        Valid,
    output logic        Err
);

    localparam int PRESCALE = (CLK_HZ / 100_000 > 1) ? CLK_HZ / 100_000 : 1;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic             rise;
    logic             fall;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_en;
    logic             is_burst;
    logic             is_one;

    state_t           state;
    state_t           state_n;
    logic [31:0]      shift_q;
    logic [31:0]      shift_n;
    logic [4:0]       bit_cnt;
    logic [4:0]       bit_cnt_n;
    logic             last_ok;
    logic             last_ok_n;
`ifdef NEC_REPEAT_EN
    logic [31:0]      last_frame;
    logic [31:0]      last_frame_n;
`endif
    logic [31:0]      data_n;
    logic             valid_n;
    logic             err_n;

    nec_edge_sync u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .IR    (IR),
        .Rise  (rise),
        .Fall  (fall)
    );

    assign tick_en  = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign is_burst = in_window(tick_cnt, BURST_MIN, BURST_MAX);
    assign is_one   = in_window(tick_cnt, ONE_MIN, ONE_MAX);

    // Width measurement: restart on every edge, otherwise count saturating ticks
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (rise || fall) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick_en) begin
            pre_cnt <= '0;
            if (tick_cnt != '1) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Decoder state, shift register, repeat memory and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            last_ok    <= 1'b0;
`ifdef NEC_REPEAT_EN
            last_frame <= '0;
`endif
            DataOut    <= '0;
            Valid      <= 1'b0;
            Err        <= 1'b0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            bit_cnt    <= bit_cnt_n;
            last_ok    <= last_ok_n;
`ifdef NEC_REPEAT_EN
            last_frame <= last_frame_n;
`endif
            DataOut    <= data_n;
            Valid      <= valid_n;
            Err        <= err_n;
        end
    end

    // Next-state decision: each edge judges the width of the pulse it ends
    always_comb begin
        state_n      = state;
        shift_n      = shift_q;
        bit_cnt_n    = bit_cnt;
        last_ok_n    = last_ok;
`ifdef NEC_REPEAT_EN
        last_frame_n = last_frame;
`endif
        data_n       = '0;
        valid_n      = 1'b0;
        err_n        = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = LEAD_LOW;
                end
            end
            LEAD_LOW: begin
                if (rise) begin
                    if (in_window(tick_cnt, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
                        state_n = LEAD_HIGH;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            LEAD_HIGH: begin
                if (fall) begin
                    if (in_window(tick_cnt, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                        state_n   = BIT_LOW;
                        bit_cnt_n = '0;
`ifdef NEC_REPEAT_EN
                    end else if (in_window(tick_cnt, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
                        state_n = RPT_STOP;
`endif
                    end else begin
                        err_n   = 1'b1;
                        state_n = LEAD_LOW;
                    end
                end
            end
            BIT_LOW: begin
                if (rise) begin
                    if (is_burst) begin
                        state_n = BIT_HIGH;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    if (is_burst || is_one) begin
                        shift_n   = {is_one, shift_q[31:1]};
                        bit_cnt_n = bit_cnt + 1'b1;
                        state_n   = (bit_cnt == 5'd31) ? STOP : BIT_LOW;
                    end else begin
                        err_n   = 1'b1;
                        state_n = LEAD_LOW;
                    end
                end
            end
            STOP: begin
                if (rise) begin
                    if (is_burst && (shift_q[23:16] == ~shift_q[31:24])) begin
                        valid_n      = 1'b1;
                        data_n       = shift_q;
                        last_ok_n    = 1'b1;
`ifdef NEC_REPEAT_EN
                        last_frame_n = shift_q;
`endif
                    end else begin
                        err_n     = 1'b1;
                        last_ok_n = 1'b0;
                    end
                    state_n = IDLE;
                end
            end
`ifdef NEC_REPEAT_EN
            RPT_STOP: begin
                if (rise) begin
                    if (is_burst && last_ok) begin
                        valid_n = 1'b1;
                        data_n  = last_frame;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        // A stalled line abandons the frame; edges always take priority
        if ((state != IDLE) && !rise && !fall && (tick_cnt >= TIMEOUT_TICKS)) begin
            state_n = IDLE;
            err_n   = 1'b1;
            valid_n = 1'b0;
            data_n  = '0;
        end
    end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder: self-checking bench for nec_ir_decoder. Runs with one
// tick per clock (CLK_HZ = 100_000) so whole frames fit in a short run.
// Honours NEC_REPEAT_EN for the repeat-code expectations.
module tb_nec_ir_decoder;

    localparam int CLK_HZ = 100_000;

    // Pulse widths in clocks, chosen well inside the legal tick windows
    localparam int LL  = 811;
    localparam int LH  = 411;
    localparam int BL  = 43;
    localparam int B0  = 43;
    localparam int B1  = 151;
    localparam int SB  = 43;
    localparam int RH  = 226;
    localparam int GAP = 60;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IR;
    logic [31:0] DataOut;
    logic        Valid;
    logic        Err;

    nec_ir_decoder #(.CLK_HZ(CLK_HZ)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IR      (IR),
        .DataOut (DataOut),
        .Valid   (Valid),
        .Err     (Err)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_FRAME, K_REPEAT, K_LEAD} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] word;
        int          lead_low;
        int          lead_high;
        int          exp_valid;
        logic [31:0] exp_data;
        int          exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    logic [31:0] valid_data = '0;
    int          cyc = 0;
    int          last_err_cyc = -1;
    logic        prev_valid = 1'b0;
    logic        prev_err   = 1'b0;
    int          v_base;
    int          e_base;
    int          resp_lat;
    bit          jit = 1'b0;

    bit          m_last_ok;
    logic [31:0] m_last_frame;

    vec_t        tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Output monitor: tallies pulses and checks pulse shape every cycle
    always @(negedge CLK) begin
        cyc++;
        if (!Valid) check("dataout_idle_zero", DataOut, 32'd0);
        if (Valid || Err) check("valid_err_exclusive", 32'(Valid & Err), 32'd0);
        if (Valid) check("valid_one_cycle", 32'(prev_valid), 32'd0);
        if (Err) check("err_one_cycle", 32'(prev_err), 32'd0);
        if (Valid) begin
            valid_cnt++;
            valid_data = DataOut;
        end
        if (Err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        prev_valid = Valid;
        prev_err   = Err;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int dur(input int base);
        return jit ? base + int'($urandom_range(12)) : base;
    endfunction

    function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    function automatic vec_t mk(input string name, input kind_t kind, input logic [31:0] word,
                                input int ll, input int lh, input int ev,
                                input logic [31:0] ed, input int ee);
        vec_t v;
        v.name = name; v.kind = kind; v.word = word; v.lead_low = ll; v.lead_high = lh;
        v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Reference model: frame accepted when command + inverted command sum to 0xFF
    task automatic model_frame(input logic [31:0] w, output int ev, output logic [31:0] ed, output int ee);
        if (8'(w[23:16] + w[31:24]) == 8'hFF) begin
            ev = 1; ed = w; ee = 0;
            m_last_ok = 1'b1;
            m_last_frame = w;
        end else begin
            ev = 0; ed = '0; ee = 1;
            m_last_ok = 1'b0;
        end
    endtask

    task automatic model_repeat(output int ev, output logic [31:0] ed, output int ee);
`ifdef NEC_REPEAT_EN
        if (m_last_ok) begin
            ev = 1; ed = m_last_frame; ee = 0;
        end else begin
            ev = 0; ed = '0; ee = 1;
        end
`else
        ev = 0; ed = '0; ee = 2;
`endif
    endtask

    task automatic drive(input logic level, input int cycles);
        IR = level;
        repeat (cycles) @(negedge CLK);
    endtask

    // Final low burst, then the rising edge; records decision latency
    task automatic close_burst(input int low_len, input bit rst_on_resp);
        drive(1'b0, low_len);
        IR = 1'b1;
        resp_lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (resp_lat == 0 && (Valid || Err)) begin
                resp_lat = k;
                if (rst_on_resp) begin
                    #1 RST_N = 1'b0;
                    #1 check("async_reset_valid", 32'(Valid), 32'd0);
                    check("async_reset_data", DataOut, 32'd0);
                end
            end
        end
        RST_N = 1'b1;
        drive(1'b1, GAP);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        drive(1'b0, dur(LL));
        drive(1'b1, dur(LH));
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, dur(BL));
            drive(1'b1, w[i] ? dur(B1) : dur(B0));
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input bit rst_on_resp);
        send_bits(w, 32);
        close_burst(dur(SB), rst_on_resp);
    endtask

    task automatic send_repeat();
        drive(1'b0, dur(LL));
        drive(1'b1, dur(RH));
        close_burst(dur(SB), 1'b0);
    endtask

    task automatic start_seq();
        v_base = valid_cnt;
        e_base = err_cnt;
        valid_data = '0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int          ev;
        int          ee;
        logic [31:0] ed;
        case (v.kind)
            K_FRAME: begin
                model_frame(v.word, ev, ed, ee);
                send_frame(v.word, 1'b0);
            end
            K_REPEAT: send_repeat();
            default: begin
                if (v.lead_high > 0) begin
                    drive(1'b0, v.lead_low);
                    drive(1'b1, v.lead_high);
                    close_burst(SB, 1'b0);
                end else begin
                    close_burst(v.lead_low, 1'b0);
                end
            end
        endcase
    endtask

    task automatic check_output(input string name, input int exp_valid, input logic [31:0] exp_data,
                                input int exp_err, input bit chk_lat);
        check({name, "_valid_count"}, valid_cnt - v_base, exp_valid);
        check({name, "_err_count"}, err_cnt - e_base, exp_err);
        check({name, "_data"}, valid_data, exp_data);
        if (chk_lat) check({name, "_latency"}, resp_lat, 32'd3);
    endtask

    initial begin
        int          ev;
        int          ee;
        logic [31:0] ed;
        logic [31:0] w;
        int          d;

        tbl[0] = mk("good_45",       K_FRAME,  32'hBA45FF00, 0, 0, 1, 32'hBA45FF00, 0);
        tbl[1] = mk("bit24_flip",    K_FRAME,  32'hBA45FF00 ^ 32'h0100_0000, 0, 0, 0, 32'h0, 1);
        tbl[2] = mk("good_15",       K_FRAME,  32'hEA15FF00, 0, 0, 1, 32'hEA15FF00, 0);
`ifdef NEC_REPEAT_EN
        tbl[3] = mk("repeat_15",     K_REPEAT, 32'h0, 0, 0, 1, 32'hEA15FF00, 0);
`else
        tbl[3] = mk("repeat_15",     K_REPEAT, 32'h0, 0, 0, 0, 32'h0, 2);
`endif
        tbl[4] = mk("short_leader",  K_LEAD,   32'h0, 501, 0, 0, 32'h0, 1);
        tbl[5] = mk("good_09",       K_FRAME,  32'hF609FF00, 0, 0, 1, 32'hF609FF00, 0);
        tbl[6] = mk("long_leader",   K_LEAD,   32'h0, 1051, 0, 0, 32'h0, 1);
        tbl[7] = mk("bad_lead_high", K_LEAD,   32'h0, LL, 321, 0, 32'h0, 2);

        IR = 1'b1;
        RST_N = 1'b0;
        m_last_ok = 1'b0;
        m_last_frame = '0;
        repeat (4) @(negedge CLK);
        check("reset_dataout", DataOut, 32'd0);
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_err", 32'(Err), 32'd0);
        RST_N = 1'b1;
        drive(1'b1, 20);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            start_seq();
            apply_stimulus(tbl[i]);
            check_output(tbl[i].name, tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_err, 1'b1);
        end

        $display("[TB] reset after 16 data bits");
        start_seq();
        send_bits(32'hBB44FF00, 16);
        RST_N = 1'b0;
        #1 check("midframe_reset_data", DataOut, 32'd0);
        check("midframe_reset_valid", 32'(Valid), 32'd0);
        m_last_ok = 1'b0;
        m_last_frame = '0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 50);
        check_output("midframe_reset", 0, 32'h0, 0, 1'b0);
        start_seq();
        model_frame(32'hBB44FF00, ev, ed, ee);
        send_frame(32'hBB44FF00, 1'b0);
        check_output("after_reset_44", 1, 32'hBB44FF00, 0, 1'b1);

        $display("[TB] reset in the Valid cycle clears the repeat memory");
        start_seq();
        model_frame(32'hF609FF00, ev, ed, ee);
        send_frame(32'hF609FF00, 1'b1);
        check_output("reset_on_valid", 1, 32'hF609FF00, 0, 1'b1);
        m_last_ok = 1'b0;
        m_last_frame = '0;
        start_seq();
        model_repeat(ev, ed, ee);
        send_repeat();
        check_output("repeat_after_reset", ev, ed, ee, 1'b1);

        $display("[TB] IR held low for 15 ms");
        start_seq();
        IR = 1'b0;
        d = cyc;
        repeat (1500) @(negedge CLK);
        drive(1'b1, GAP);
        check_output("held_low", 0, 32'h0, 1, 1'b0);
        d = last_err_cyc - d;
        n_checks++;
        if (d < 1095 || d > 1115) begin
            n_fail++;
            $display("[TB] FAIL timeout_time: Err at %0d cycles after fall, expected 1095..1115", d);
        end

        $display("[TB] randomized frames");
        jit = 1'b1;
        for (int it = 0; it < 2; it++) begin
            w = nec_word(8'($urandom), 8'($urandom));
            if ($urandom_range(1) == 1) w = w ^ (32'd1 << $urandom_range(31));
            start_seq();
            model_frame(w, ev, ed, ee);
            send_frame(w, 1'b0);
            check_output($sformatf("rand_frame%0d", it), ev, ed, ee, 1'b1);
            if ($urandom_range(1) == 1) begin
                start_seq();
                model_repeat(ev, ed, ee);
                send_repeat();
                check_output($sformatf("rand_repeat%0d", it), ev, ed, ee, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
